tlb_cam: RTL and testbench
==========================

Name: tlb_cam

Overview:
- Parametrised, fully associative translation lookaside buffer shared by the instruction and data paths of the MIPS core.
- Translates a virtual address to a physical address with a one-cycle registered lookup.
- Accepts refill entries from the miss handler through a valid/ready handshake.
- Supports full flush, replaces entries using invalid-first then round-robin, and reports occupancy and a saturating miss count.

Parameters:
- ENTRIES, 16: number of entries; power of two, 2..64.
- VA_W, 16: virtual address width.
- PA_W, 16: physical address width.
- OFF_W, 8: page offset width; VPN_W = VA_W-OFF_W and PPN_W = PA_W-OFF_W are derived.
- MISS_CNT_W, 16: width of the miss counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- lk_valid  in  1  lookup request this cycle.
- lk_vaddr  in  VA_W  virtual address to translate.
- rsp_valid  out  1  lookup result valid; one cycle after lk_valid.
- rsp_hit  out  1  translation found; qualified by rsp_valid.
- rsp_paddr  out  PA_W  {PPN, offset} on hit; 0 on miss.
- wr_valid  in  1  refill request.
- wr_ready  out  1  refill accepted when wr_valid && wr_ready.
- wr_vpn  in  VPN_W  refill virtual page number.
- wr_ppn  in  PPN_W  refill physical page number.
- flush  in  1  invalidate all entries.
- occupancy  out  clog2(ENTRIES)+1  number of valid entries.
- miss_count  out  MISS_CNT_W  lookups that missed; saturates.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All valid bits 0; replacement pointer 0.
  - rsp_valid=0, rsp_hit=0, rsp_paddr=0, occupancy=0, miss_count=0, wr_ready=1.
  - VPN/PPN storage is not reset.
- Lookup:
  - In cycle N, lk_valid compares lk_vaddr[VA_W-1:OFF_W] against all valid entries in parallel.
  - In cycle N+1, rsp_valid=1 and rsp_hit reflects the match.
  - On hit, rsp_paddr = {PPN, offset registered from cycle N}.
  - One lookup per cycle is accepted, fully pipelined with no stall.
  - Without lk_valid, rsp_valid=0 next cycle and rsp_hit/rsp_paddr are driven to 0.
- Duplicate VPNs never exist. Hardware enforces this on the write path (see refill step 1). Should multiple matches occur anyway, the lowest index wins.
- Miss counter:
  - Increments by 1 on every rsp_valid && !rsp_hit.
  - Holds at all-ones once saturated.
  - Cleared only by reset; flush does not clear it.
- Refill handshake:
  - wr_ready is 0 in the cycle flush is high, otherwise 1.
  - The write commits at the clock edge where wr_valid && wr_ready.
  - Victim selection, in priority order:
    1. A valid entry with the same VPN: its PPN is overwritten and occupancy is unchanged.
    2. Otherwise, the lowest-index invalid entry: occupancy += 1.
    3. Otherwise (full), the entry at the replacement pointer; the pointer then increments modulo ENTRIES and occupancy is unchanged.
  - The pointer advances only on case 3.
- Flush:
  - Clears all valid bits and sets occupancy=0 at that edge; the pointer resets to 0.
  - A concurrent refill is refused via wr_ready=0, so the requester must hold wr_valid.
- Simultaneous lookup and write to the same VPN in cycle N: the lookup sees pre-write state (may miss). A lookup in N+1 hits.
- Simultaneous lookup and flush in cycle N: the lookup sees pre-flush state. Lookups from N+1 miss.
- Reset mid-lookup: rsp_valid drops immediately; the pending response is discarded.
- Internal FSM, for write arbitration: states READY and FLUSHING.
  - READY -> FLUSHING when flush=1.
  - FLUSHING -> READY when flush=0.
  - FLUSHING lasts as long as flush is held, with wr_ready=0 throughout.

Decomposition:
- Shared package mips_mem_pkg:
  - Default widths VA_W, PA_W, OFF_W.
  - tlb_entry_t struct {valid, vpn, ppn}.
  - Function clog2 for derived widths.
- One natural sub-module, tlb_match: combinational parallel compare plus priority encoder. It returns hit, index, the invalid-slot index, and a found-invalid flag. It is instantiated twice: once for the lookup VPN and once for the write VPN.

Test Plan:
- Reset, then lookup of 0x1234 -> next cycle rsp_valid=1, rsp_hit=0, rsp_paddr=0, miss_count=1, occupancy=0.
- Refill vpn 0x12 -> ppn 0xAB, then lookup 0x1234 -> rsp_hit=1, rsp_paddr=0xAB34, occupancy=1.
- Refill 0x12 -> 0xCD (duplicate), then lookup 0x1234 -> rsp_paddr=0xCD34, occupancy stays 1.
- Fill 16 distinct VPNs 0x00..0x0F, then refill VPN 0x20 -> entry 0 (vpn 0x00) evicted:
  - Lookup 0x0000 misses; lookup 0x2000 hits.
  - A further refill of 0x21 evicts entry 1.
- flush held 3 cycles while wr_valid=1 -> wr_ready=0 for 3 cycles; occupancy=0 after the first edge; the write commits the cycle after flush falls; occupancy=1.
- Force miss_count to all-ones minus 1 via repeated misses with MISS_CNT_W=4 -> after 16 misses it holds at 15. Lookup and refill of the same VPN in one cycle -> that response misses and the next-cycle lookup hits.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared memory-subsystem definitions for the MIPS core: default address
// geometry, the TLB entry layout, the TLB write-arbitration states and a
// constant-friendly ceiling-log2 helper.
package mips_mem_pkg;

    localparam int unsigned DEF_VA_W  = 16;
    localparam int unsigned DEF_PA_W  = 16;
    localparam int unsigned DEF_OFF_W = 8;
    localparam int unsigned DEF_VPN_W = DEF_VA_W - DEF_OFF_W;
    localparam int unsigned DEF_PPN_W = DEF_PA_W - DEF_OFF_W;

    // One translation in the default geometry.
    typedef struct packed {
        logic                 valid;
        logic [DEF_VPN_W-1:0] vpn;
        logic [DEF_PPN_W-1:0] ppn;
    } tlb_entry_t;

    // Write-side arbitration: refills are refused while a flush is held.
    typedef enum logic [0:0] {
        ST_READY    = 1'b0,
        ST_FLUSHING = 1'b1
    } tlb_wr_state_e;

    // Ceiling log2, usable in parameter expressions (clog2(1) = 0).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Parallel VPN compare across all entries with priority encoding. Reports
// the lowest-index valid match and the lowest-index invalid slot.
module tlb_match
    import mips_mem_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned VPN_W   = 8,
    parameter int unsigned IDX_W   = clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0] valid,
    input  logic [VPN_W-1:0]   vpn [ENTRIES],
    input  logic [VPN_W-1:0]   key,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic               inv_found,
    output logic [IDX_W-1:0]   inv_idx
);

    // Scan from the top down so the lowest matching / free index is left last.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = {IDX_W{1'b0}};
        inv_found = 1'b0;
        inv_idx   = {IDX_W{1'b0}};
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (valid[i] && (vpn[i] == key)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end else begin
                hit     = hit;
                hit_idx = hit_idx;
            end
            if (!valid[i]) begin
                inv_found = 1'b1;
                inv_idx   = IDX_W'(i);
            end else begin
                inv_found = inv_found;
                inv_idx   = inv_idx;
            end
        end
    end

endmodule

// File: rtl/tlb_cam.sv
// Fully associative TLB: one-cycle registered lookup, valid/ready refill with
// same-VPN overwrite, invalid-first then round-robin replacement, full flush,
// occupancy count and a saturating miss counter.
module tlb_cam
    import mips_mem_pkg::*;
#(
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned VA_W       = DEF_VA_W,
    parameter int unsigned PA_W       = DEF_PA_W,
    parameter int unsigned OFF_W      = DEF_OFF_W,
    parameter int unsigned MISS_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      lk_valid,
    input  logic [VA_W-1:0]           lk_vaddr,
    output logic                      rsp_valid,
    output logic                      rsp_hit,
    output logic [PA_W-1:0]           rsp_paddr,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [VA_W-OFF_W-1:0]     wr_vpn,
    input  logic [PA_W-OFF_W-1:0]     wr_ppn,
    input  logic                      flush,
    output logic [clog2(ENTRIES):0]   occupancy,
    output logic [MISS_CNT_W-1:0]     miss_count
);

    localparam int unsigned VPN_W = VA_W - OFF_W;
    localparam int unsigned PPN_W = PA_W - OFF_W;
    localparam int unsigned IDX_W = clog2(ENTRIES);
    localparam int unsigned OCC_W = IDX_W + 1;

    // Entry storage: valid bits are reset, page numbers are not.
    logic [ENTRIES-1:0]    valid_r;
    logic [VPN_W-1:0]      vpn_r [ENTRIES];
    logic [PPN_W-1:0]      ppn_r [ENTRIES];
    logic [IDX_W-1:0]      ptr_r;
    logic [OCC_W-1:0]      occ_r;
    logic [MISS_CNT_W-1:0] miss_r;
    logic                  rsp_valid_r;
    logic                  rsp_hit_r;
    logic [PA_W-1:0]       rsp_paddr_r;
    tlb_wr_state_e         state_r;
    tlb_wr_state_e         state_s;
    logic                  wr_ready_s;
    logic                  wr_fire_s;

    logic [VPN_W-1:0]      lk_vpn_s;
    logic                  lk_hit_s;
    logic [IDX_W-1:0]      lk_idx_s;
    logic                  lk_inv_found_s;
    logic [IDX_W-1:0]      lk_inv_idx_s;
    logic                  wr_hit_s;
    logic [IDX_W-1:0]      wr_hit_idx_s;
    logic                  wr_inv_found_s;
    logic [IDX_W-1:0]      wr_inv_idx_s;
    logic [IDX_W-1:0]      wr_idx_s;
    logic                  wr_alloc_s;
    logic                  wr_evict_s;
    logic                  unused_s;

    assign lk_vpn_s  = lk_vaddr[VA_W-1:OFF_W];
    assign wr_fire_s = wr_valid && wr_ready_s;
    // The lookup side never allocates, so its free-slot outputs are dropped.
    assign unused_s  = ^{lk_inv_found_s, lk_inv_idx_s};

    tlb_match #(
        .ENTRIES (ENTRIES),
        .VPN_W   (VPN_W),
        .IDX_W   (IDX_W)
    ) u_match_lk (
        .valid     (valid_r),
        .vpn       (vpn_r),
        .key       (lk_vpn_s),
        .hit       (lk_hit_s),
        .hit_idx   (lk_idx_s),
        .inv_found (lk_inv_found_s),
        .inv_idx   (lk_inv_idx_s)
    );

    tlb_match #(
        .ENTRIES (ENTRIES),
        .VPN_W   (VPN_W),
        .IDX_W   (IDX_W)
    ) u_match_wr (
        .valid     (valid_r),
        .vpn       (vpn_r),
        .key       (wr_vpn),
        .hit       (wr_hit_s),
        .hit_idx   (wr_hit_idx_s),
        .inv_found (wr_inv_found_s),
        .inv_idx   (wr_inv_idx_s)
    );

    // Write-arbitration state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_READY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and ready: refills are refused in any cycle flush is high.
    always_comb begin
        state_s    = state_r;
        wr_ready_s = 1'b1;
        case (state_r)
            ST_READY: begin
                if (flush) begin
                    state_s    = ST_FLUSHING;
                    wr_ready_s = 1'b0;
                end else begin
                    state_s    = ST_READY;
                    wr_ready_s = 1'b1;
                end
            end
            ST_FLUSHING: begin
                if (flush) begin
                    state_s    = ST_FLUSHING;
                    wr_ready_s = 1'b0;
                end else begin
                    state_s    = ST_READY;
                    wr_ready_s = 1'b1;
                end
            end
            default: begin
                state_s    = ST_READY;
                wr_ready_s = !flush;
            end
        endcase
    end

    // Victim choice: same-VPN overwrite, else lowest free slot, else pointer.
    always_comb begin
        wr_idx_s   = ptr_r;
        wr_alloc_s = 1'b0;
        wr_evict_s = 1'b0;
        if (wr_hit_s) begin
            wr_idx_s = wr_hit_idx_s;
        end else if (wr_inv_found_s) begin
            wr_idx_s   = wr_inv_idx_s;
            wr_alloc_s = 1'b1;
        end else begin
            wr_idx_s   = ptr_r;
            wr_evict_s = 1'b1;
        end
    end

    // Valid bits, occupancy and replacement pointer; flush takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {ENTRIES{1'b0}};
            occ_r   <= {OCC_W{1'b0}};
            ptr_r   <= {IDX_W{1'b0}};
        end else if (flush) begin
            valid_r <= {ENTRIES{1'b0}};
            occ_r   <= {OCC_W{1'b0}};
            ptr_r   <= {IDX_W{1'b0}};
        end else if (wr_fire_s) begin
            valid_r[wr_idx_s] <= 1'b1;
            if (wr_alloc_s) begin
                occ_r <= occ_r + OCC_W'(1);
            end else begin
                occ_r <= occ_r;
            end
            if (wr_evict_s) begin
                ptr_r <= ptr_r + IDX_W'(1);
            end else begin
                ptr_r <= ptr_r;
            end
        end else begin
            valid_r <= valid_r;
            occ_r   <= occ_r;
            ptr_r   <= ptr_r;
        end
    end

    // Page-number storage; contents are only meaningful under a valid bit.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            vpn_r[wr_idx_s] <= wr_vpn;
            ppn_r[wr_idx_s] <= wr_ppn;
        end
    end

    // Registered lookup response; a cycle without a request returns zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_hit_r   <= 1'b0;
            rsp_paddr_r <= {PA_W{1'b0}};
        end else begin
            rsp_valid_r <= lk_valid;
            rsp_hit_r   <= lk_valid && lk_hit_s;
            if (lk_valid && lk_hit_s) begin
                rsp_paddr_r <= {ppn_r[lk_idx_s], lk_vaddr[OFF_W-1:0]};
            end else begin
                rsp_paddr_r <= {PA_W{1'b0}};
            end
        end
    end

    // Saturating miss counter, updated on the edge that registers the miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_r <= {MISS_CNT_W{1'b0}};
        end else if (lk_valid && !lk_hit_s && (miss_r != {MISS_CNT_W{1'b1}})) begin
            miss_r <= miss_r + MISS_CNT_W'(1);
        end else begin
            miss_r <= miss_r;
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_hit    = rsp_hit_r;
    assign rsp_paddr  = rsp_paddr_r;
    assign wr_ready   = wr_ready_s;
    assign occupancy  = occ_r;
    assign miss_count = miss_r;

endmodule

// File: tb/tb_tlb_cam.sv
// Directed bench for tlb_cam (16 entries, 16-bit addresses, 4-bit miss counter).
module tb_tlb_cam;

    logic        clk;
    logic        rst_n;
    logic        lk_valid;
    logic [15:0] lk_vaddr;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [15:0] rsp_paddr;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_vpn;
    logic [7:0]  wr_ppn;
    logic        flush;
    logic [4:0]  occupancy;
    logic [3:0]  miss_count;

    int checks   = 0;
    int failures = 0;
    int exp_miss = 0;

    tlb_cam #(
        .ENTRIES    (16),
        .VA_W       (16),
        .PA_W       (16),
        .OFF_W      (8),
        .MISS_CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lk_valid   (lk_valid),
        .lk_vaddr   (lk_vaddr),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_paddr  (rsp_paddr),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_vpn     (wr_vpn),
        .wr_ppn     (wr_ppn),
        .flush      (flush),
        .occupancy  (occupancy),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one lookup and check the response one cycle later.
    task automatic lookup(input string tag, input logic [15:0] va,
                          input logic exp_hit, input logic [15:0] exp_pa);
        @(negedge clk);
        lk_valid = 1'b1;
        lk_vaddr = va;
        @(negedge clk);
        lk_valid = 1'b0;
        if (!exp_hit && exp_miss < 15) exp_miss++;
        check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        check({tag, "_hit"}, 32'(rsp_hit), 32'(exp_hit));
        check({tag, "_pa"}, 32'(rsp_paddr), 32'(exp_pa));
        check({tag, "_miss"}, 32'(miss_count), 32'(exp_miss));
    endtask

    // Present a refill and hold it until accepted (bounded).
    task automatic refill(input string tag, input logic [7:0] vpn, input logic [7:0] ppn);
        int waited;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_vpn   = vpn;
        wr_ppn   = ppn;
        #1;
        waited = 0;
        while (!wr_ready && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check({tag, "_rdy"}, 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        lk_valid = 1'b0;
        lk_vaddr = 16'h0000;
        wr_valid = 1'b0;
        wr_vpn   = 8'h00;
        wr_ppn   = 8'h00;
        flush    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_vld", 32'(rsp_valid), 32'd0);
        check("rst_hit", 32'(rsp_hit), 32'd0);
        check("rst_pa", 32'(rsp_paddr), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_miss", 32'(miss_count), 32'd0);
        check("rst_rdy", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;

        // Cold miss, then refill and hit, then same-VPN overwrite.
        lookup("cold", 16'h1234, 1'b0, 16'h0000);
        check("cold_occ", 32'(occupancy), 32'd0);
        refill("r12ab", 8'h12, 8'hAB);
        lookup("hit_ab", 16'h1234, 1'b1, 16'hAB34);
        check("hit_ab_occ", 32'(occupancy), 32'd1);
        refill("r12cd", 8'h12, 8'hCD);
        lookup("hit_cd", 16'h1234, 1'b1, 16'hCD34);
        check("hit_cd_occ", 32'(occupancy), 32'd1);

        // Single-cycle flush empties the table and rewinds the pointer.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl1_occ", 32'(occupancy), 32'd0);

        // Fill all 16 entries with VPN i -> PPN 0x80+i.
        for (int i = 0; i < 16; i++) begin
            refill($sformatf("fill%0d", i), 8'(i), 8'(8'h80 + i));
        end
        check("full_occ", 32'(occupancy), 32'd16);

        // Round-robin eviction: 0x20 replaces entry 0, 0x21 replaces entry 1.
        refill("r20", 8'h20, 8'h55);
        check("r20_occ", 32'(occupancy), 32'd16);
        lookup("ev0", 16'h0000, 1'b0, 16'h0000);
        lookup("new20", 16'h2000, 1'b1, 16'h5500);
        lookup("keep1", 16'h0177, 1'b1, 16'h8177);
        refill("r21", 8'h21, 8'h66);
        lookup("ev1", 16'h0100, 1'b0, 16'h0000);
        lookup("new21", 16'h2142, 1'b1, 16'h6642);
        lookup("keep2", 16'h0205, 1'b1, 16'h8205);
        check("ev_occ", 32'(occupancy), 32'd16);

        // Flush held three cycles against a pending refill.
        @(negedge clk);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_vpn   = 8'h30;
        wr_ppn   = 8'h77;
        #1;
        check("flh_rdy0", 32'(wr_ready), 32'd0);
        @(negedge clk);
        #1;
        check("flh_occ0", 32'(occupancy), 32'd0);
        check("flh_rdy1", 32'(wr_ready), 32'd0);
        @(negedge clk);
        #1;
        check("flh_rdy2", 32'(wr_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flh_rdy3", 32'(wr_ready), 32'd1);
        check("flh_occ3", 32'(occupancy), 32'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        check("flh_occ4", 32'(occupancy), 32'd1);
        lookup("flh_new", 16'h3000, 1'b1, 16'h7700);
        lookup("flh_gone", 16'h2000, 1'b0, 16'h0000);

        // Drive the 4-bit miss counter into saturation.
        for (int i = 0; i < 16; i++) begin
            lookup($sformatf("sat%0d", i), 16'(16'h4000 + i), 1'b0, 16'h0000);
        end
        check("sat_hold", 32'(miss_count), 32'd15);

        // Lookup and refill of the same VPN in one cycle.
        @(negedge clk);
        lk_valid = 1'b1;
        lk_vaddr = 16'h5011;
        wr_valid = 1'b1;
        wr_vpn   = 8'h50;
        wr_ppn   = 8'h99;
        @(negedge clk);
        wr_valid = 1'b0;
        check("same_miss", 32'(rsp_hit), 32'd0);
        check("same_vld", 32'(rsp_valid), 32'd1);
        check("same_cnt", 32'(miss_count), 32'd15);
        @(negedge clk);
        lk_valid = 1'b0;
        check("same_hit", 32'(rsp_hit), 32'd1);
        check("same_pa", 32'(rsp_paddr), 32'h9911);
        check("same_occ", 32'(occupancy), 32'd2);

        // Reset arriving with a response outstanding.
        @(negedge clk);
        lk_valid = 1'b1;
        lk_vaddr = 16'h3000;
        @(posedge clk);
        #2;
        lk_valid = 1'b0;
        check("mid_vld1", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_vld0", 32'(rsp_valid), 32'd0);
        check("mid_hit0", 32'(rsp_hit), 32'd0);
        check("mid_occ0", 32'(occupancy), 32'd0);
        check("mid_miss0", 32'(miss_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
